alu_mul_seq: RTL
================

Name: alu_mul_seq

Overview:
- Iterative shift-add sequencer that computes the low XLEN bits of an unsigned multiply.
- It reuses the core's single ALU adder (ALUControl add code) instead of instantiating a multiplier.
- It sits between the core datapath and the ALU. When idle, the core's ALU operands and control pass straight through. While a multiply runs, the sequencer owns the ALU.
- Start/busy/done handshake toward the control unit; the core stalls while busy is high.

Parameters:
- XLEN, 32, operand/result width; the loop runs at most XLEN iterations.
- EARLY_EXIT, 1, when 1 the loop terminates once the remaining multiplier bits are all zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a multiply; sampled only in IDLE.
- op_a  in  XLEN  multiplicand, captured on an accepted start.
- op_b  in  XLEN  multiplier, captured on an accepted start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when product is valid.
- product  out  XLEN  low XLEN bits of op_a*op_b; held until the next accepted start.
- core_a  in  XLEN  core ALU operand a (pass-through source).
- core_b  in  XLEN  core ALU operand b (pass-through source).
- core_ctrl  in  3  core ALUControl (pass-through source).
- alu_a  out  XLEN  to ALU operand a.
- alu_b  out  XLEN  to ALU operand b.
- alu_ctrl  out  3  to ALU ALUControl.
- alu_rslt  in  XLEN  ALU result.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset state: state=IDLE; acc, mcand, mplier, cnt, product all 0; busy=0; done=0.
- Reset mid-RUN: aborts the operation, no done pulse, and ALU ownership returns to the core immediately.
- ALU mux: state==IDLE gives alu_a/alu_b/alu_ctrl = core_a/core_b/core_ctrl, purely combinational. Any other state gives alu_a=acc, alu_b = mplier[0] ? mcand : 0, and alu_ctrl=ALU_ADD (3'b000).

FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - mcand<=op_a, mplier<=op_b, acc<=0, cnt<=0.
  - If EARLY_EXIT and op_b==0, go to DONE; otherwise go to RUN.
- RUN, every cycle:
  - acc<=alu_rslt; mcand<=mcand<<1 (zero fill); mplier<=mplier>>1; cnt<=cnt+1.
  - Go to DONE when cnt==XLEN-1, or when EARLY_EXIT and (mplier>>1)==0.
- DONE:
  - product<=acc, done=1 for exactly this cycle, then go to IDLE.
  - product must be registered from acc on entry to DONE, so it is valid in the same cycle done is high.
  - Implement this as product<=alu_rslt on the final RUN cycle, or product<=0 on the zero shortcut.
- start outside IDLE is ignored and not queued; operands change while busy has no effect.
- Arithmetic: modulo 2^XLEN, unsigned; overflow beyond XLEN bits is discarded; the ALU zero output is unused.
- Latency, start-accept cycle to done cycle:
  - N+1 cycles, where N = number of RUN cycles.
  - N = XLEN when EARLY_EXIT=0.
  - N = (index of highest set bit of op_b)+1 when EARLY_EXIT=1.
  - op_b==0 with EARLY_EXIT=1 gives done 1 cycle after start.
- Back-to-back: the earliest next start is accepted in the IDLE cycle following DONE.

Decomposition:
- Shared package core_pkg:
  - ALU control localparams ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101.
  - mul_state_t enum {IDLE, RUN, DONE}.
  - The ALU and decoder use the same constants.
- No new sub-module. Reuse the existing mux_2 for the three ALU-facing muxes (XLEN, XLEN, 3 bits).

Test Plan:
- Pass-through: IDLE, core_a=0x000000F0, core_b=0x0000003C, core_ctrl=3'b010 -> alu_a/alu_b/alu_ctrl equal the inputs the same cycle; ALU rslt 0x00000030.
- Early exit: op_a=7, op_b=6, EARLY_EXIT=1 -> busy for 3 RUN + 1 DONE cycle; done pulses 4 cycles after start; product=42.
- Full length and wrap: op_a=op_b=0xFFFFFFFF -> 32 RUN cycles; done 33 cycles after start; product=0x00000001. Also op_a=0x80000000, op_b=2 -> product=0.
- Zero multiplier: op_b=0, op_a=0x1234 -> done 1 cycle after start; product=0. With EARLY_EXIT=0: done after 33 cycles, product=0.
- Ignored start: start pulsed with new operands during RUN of 7*6 -> still product=42, single done pulse, no second operation.
- Reset mid-op: rst_n low during cycle 10 of 0xFFFF*0xFFFF -> busy=0, done=0, product=0, ALU pass-through restored asynchronously. A fresh 3*5 after release gives 15.

Source files
------------

// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
//   Constants and types shared by the core's ALU, decoder and multiply
//   sequencer.
//   ALU_*       : ALUControl encodings understood by the single core ALU.
//   mul_state_t : state of the iterative shift-add multiply sequencer.
// ----------------------------------------------------------------------------
package core_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage : core_pkg

// File: rtl/mux_2.sv
// ----------------------------------------------------------------------------
// mux_2
//   Generic two-input multiplexer.
//   d0, d1 : data inputs (WIDTH bits)
//   s      : select, 0 -> d0, 1 -> d1
//   y      : selected data (WIDTH bits)
// ----------------------------------------------------------------------------
module mux_2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? d1 : d0;

endmodule : mux_2

// File: rtl/alu_mul_seq.sv
// ----------------------------------------------------------------------------
// alu_mul_seq
//   Iterative shift-add sequencer producing the low XLEN bits of an unsigned
//   multiply by borrowing the core's single ALU adder. In IDLE the core's ALU
//   operands/control pass straight through; otherwise the sequencer drives
//   the ALU with acc + (mplier[0] ? mcand : 0).
//
//   clk, rst_n           : clock (rising edge), async active-low reset
//   start, op_a, op_b    : multiply request and operands (sampled in IDLE)
//   busy, done, product  : handshake toward control unit and result
//   core_a/core_b/ctrl   : core ALU inputs (pass-through sources)
//   alu_a/alu_b/alu_ctrl : drive to the ALU
//   alu_rslt             : ALU result
// ----------------------------------------------------------------------------
module alu_mul_seq
    import core_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product,
    input  logic [XLEN-1:0] core_a,
    input  logic [XLEN-1:0] core_b,
    input  logic [2:0]      core_ctrl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_rslt
);

    localparam int unsigned CW = $clog2(XLEN) + 1;

    mul_state_t      state_q,   state_d;
    logic [XLEN-1:0] acc_q,     acc_d;
    logic [XLEN-1:0] mcand_q,   mcand_d;
    logic [XLEN-1:0] mplier_q,  mplier_d;
    logic [XLEN-1:0] product_q, product_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic            busy_q,    busy_d;
    logic            done_q,    done_d;

    logic            own_alu;
    logic [XLEN-1:0] seq_b;
    logic            last_run;

    // Ownership follows the state register directly, so an async reset hands
    // the ALU back to the core without waiting for a clock edge.
    assign own_alu = (state_q != IDLE);
    assign seq_b   = mplier_q[0] ? mcand_q : '0;

    // Stop after XLEN iterations, or earlier once no set multiplier bits
    // remain above the one being consumed this cycle.
    assign last_run = (cnt_q == CW'(XLEN - 1)) ||
                      (EARLY_EXIT && (mplier_q[XLEN-1:1] == '0));

    mux_2 #(.WIDTH(XLEN)) u_mux_a (
        .d0 (core_a),
        .d1 (acc_q),
        .s  (own_alu),
        .y  (alu_a)
    );

    mux_2 #(.WIDTH(XLEN)) u_mux_b (
        .d0 (core_b),
        .d1 (seq_b),
        .s  (own_alu),
        .y  (alu_b)
    );

    mux_2 #(.WIDTH(3)) u_mux_ctrl (
        .d0 (core_ctrl),
        .d1 (ALU_ADD),
        .s  (own_alu),
        .y  (alu_ctrl)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    if (EARLY_EXIT && (op_b == '0)) begin
                        state_d   = DONE;
                        product_d = '0;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d    = alu_rslt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (last_run) begin
                    // Capture the final sum now so product is valid alongside done.
                    state_d   = DONE;
                    product_d = alu_rslt;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule : alu_mul_seq
